kbd_scan_decoder: RTL and testbench
===================================

# kbd_scan_decoder

Consumer of the keyboard lookup ROM (`kbdrom`). It takes PS/2 set-2 scancode bytes from the PS/2 receiver and tracks break/extended prefixes and the Shift/Ctrl/CapsLock modifiers. For each printable make code it reads the 14-bit ROM entry and queues the resulting 7-bit ASCII character in a 4-entry output FIFO, which the terminal/VGA text writer drains.

## Interface
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- scan_data  in  8  scancode byte from the PS/2 receiver.
- scan_valid  in  1  one-cycle strobe; scan_data is valid this cycle.
- rom_ad  out  7  ROM address (scancode[6:0]).
- rom_ce  out  1  ROM read enable.
- rom_dout  in  14  ROM data, registered inside the ROM:
  - [6:0] unshifted ASCII.
  - [13:7] shifted ASCII.
  - 0 means no character.
- ascii  out  7  FIFO head character.
- ascii_valid  out  1  FIFO not empty.
- ascii_ready  in  1  consumer accepts head when ascii_valid & ascii_ready.
- caps_led  out  1  CapsLock state.
- overflow  out  1  sticky flag: a byte or character was dropped. Cleared only by reset.

## Operation
- Prefix flags `brk` (set by F0) and `ext` (set by E0). Every non-prefix byte clears both after it is processed.
- Modifier byte handling:
  - 0x12, 0x59: lshift/rshift set on make, clear on break.
  - 0x14: ctrl, with or without E0. Set on make, clear on break.
  - 0x58: make toggles caps; break ignored.
  - Modifiers never reach the ROM.
- Other bytes:
  - Other break codes: ignored.
  - Extended make codes other than E0 4A and E0 5A: ignored.
  - Bytes 0x80–0xFF other than E0/F0 (AA, FA, FE, EE, FF, 83): ignored, and they clear the prefix flags.
- FSM states:
  - IDLE: on scan_valid with a lookup-eligible make code, latch code[6:0] and go to FETCH. Any other byte updates flags and stays in IDLE.
  - FETCH (1 cycle): rom_ce=1, rom_ad=latched code; go to DATA.
  - DATA (1 cycle): rom_dout is valid. Compute the character, push it if non-zero, return to IDLE.
- Character computation:
  - shift = lshift|rshift.
  - Take [13:7] if shift, else [6:0].
  - If caps=1 and the unshifted entry is 0x61–0x7A, invert the shift selection.
  - If ctrl=1 and the result is 0x40–0x7F, output result & 0x1F.
  - Zero result: nothing pushed.
- scan_valid while in FETCH or DATA: byte dropped, overflow=1.
- FIFO: first-word-fall-through.
  - A push is accepted if not full, or if a pop occurs the same cycle.
  - Push when full with no pop: character dropped, overflow=1.
  - Pop from empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Reset mid-operation: FSM returns to IDLE. FIFO, prefixes, modifiers, caps and overflow are all cleared. Any in-flight lookup is discarded.

## Timing
- Reset values: rom_ad=0, rom_ce=0, ascii=0, ascii_valid=0, caps_led=0, overflow=0.
- rom_ad and rom_ce are registered; rom_ce is high for exactly one cycle per lookup.
- Latency with an empty FIFO:
  - Cycle 0: scan_valid.
  - Cycle 1: rom_ce=1.
  - Cycle 2: DATA, push.
  - Cycle 3: ascii_valid=1, ascii valid.
- Throughput: one lookup per 3 cycles. The next byte is accepted from cycle 3 (IDLE).
- caps_led toggles in the cycle after the 0x58 make strobe.
- ascii and ascii_valid are registered FIFO outputs. After a pop they update on the next edge.

## Test plan
- Bench ROM: 0x1C = {0x41, 0x61}, 0x16 = {0x21, 0x31}, 0x5A = {0x0D, 0x0D}, 0x05 = 0.
- Basic lookup: byte 0x1C, ready=1 → rom_ce in cycle 1 with rom_ad=0x1C; ascii=0x61 with valid in cycle 3; FIFO empty afterwards.
- Shift: 12, 16, F0 12, 16 → outputs 0x21 then 0x31.
- CapsLock and Ctrl:
  - 58, 1C → 0x41, caps_led=1.
  - Then 12, 1C → 0x61.
  - Then F0 12, 14, 1C → 0x01.
- Ignored and extended codes:
  - 05 → nothing pushed.
  - F0 1C → nothing pushed.
  - E0 75 → nothing pushed.
  - E0 5A → 0x0D.
  - AA → ignored.
- FIFO overflow: ready=0, send 1C five times → 4 entries queued, overflow=1. Then ready=1 → four 0x61 drained, ascii_valid drops.
- Reset mid-lookup: reset asserted in cycle 1 after 1C → no push, all outputs 0. A new 1C afterwards decodes normally to 0x61.

Source files
------------

// File: rtl/kbd_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kbd_scan_decoder                                                     |
// | PS/2 set-2 scancodes -> ASCII through kbdrom, FWFT output FIFO.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module kbd_scan_decoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  scan_data,
   input  logic        scan_valid,
   output logic [6:0]  rom_ad,
   output logic        rom_ce,
   input  logic [13:0] rom_dout,
   output logic [6:0]  ascii,
   output logic        ascii_valid,
   input  logic        ascii_ready,
   output logic        caps_led,
   output logic        overflow
);

   localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DATA  = 2'd2
   } state_t;

   state_t r_state, w_state_next;

   logic r_brk, r_ext, r_lshift, r_rshift, r_ctrl, r_caps, r_overflow;

   logic w_accept, w_is_e0, w_is_f0, w_is_mod, w_lookup;
   logic w_push_req, w_push, w_pop, w_drop, w_keep, w_sel_shift;
   logic [6:0] w_raw, w_char, w_head_next;

   logic [6:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_rd_ptr, r_wr_ptr, w_rd_next;
   logic [c_CW-1:0] r_count, w_count_next;

   // Byte classification; only meaningful while idle.
   assign w_accept = scan_valid && (r_state == S_IDLE);
   assign w_is_e0  = (scan_data == 8'hE0);
   assign w_is_f0  = (scan_data == 8'hF0);
   assign w_is_mod = (scan_data == 8'h12) || (scan_data == 8'h59) ||
                     (scan_data == 8'h14) || (scan_data == 8'h58);
   assign w_lookup = w_accept && !scan_data[7] && !w_is_mod && !r_brk &&
                     (!r_ext || (scan_data == 8'h4A) || (scan_data == 8'h5A));

   // CapsLock only inverts the shift choice for letter keys.
   always_comb begin
      w_sel_shift = r_lshift | r_rshift;
      if (r_caps && (rom_dout[6:0] >= 7'h61) && (rom_dout[6:0] <= 7'h7A))
         w_sel_shift = !w_sel_shift;
      w_raw  = w_sel_shift ? rom_dout[13:7] : rom_dout[6:0];
      w_char = (r_ctrl && w_raw[6]) ? {2'b00, w_raw[4:0]} : w_raw;
   end

   always_comb begin
      w_state_next = r_state;
      w_push_req   = 1'b0;
      case (r_state)
         S_IDLE:  if (w_lookup) w_state_next = S_FETCH;
         S_FETCH: w_state_next = S_DATA;
         S_DATA: begin
            w_state_next = S_IDLE;
            w_push_req   = (w_char != 7'd0);
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         rom_ce  <= 1'b0;
         rom_ad  <= 7'd0;
      end else begin
         r_state <= w_state_next;
         rom_ce  <= (w_state_next == S_FETCH);
         if (w_lookup)
            rom_ad <= scan_data[6:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_brk    <= 1'b0;
         r_ext    <= 1'b0;
         r_lshift <= 1'b0;
         r_rshift <= 1'b0;
         r_ctrl   <= 1'b0;
         r_caps   <= 1'b0;
      end else if (w_accept) begin
         if (w_is_e0) begin
            r_ext <= 1'b1;
         end else if (w_is_f0) begin
            r_brk <= 1'b1;
         end else begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
            case (scan_data)
               8'h12:   r_lshift <= !r_brk;
               8'h59:   r_rshift <= !r_brk;
               8'h14:   r_ctrl   <= !r_brk;
               8'h58:   if (!r_brk) r_caps <= !r_caps;
               default: ;
            endcase
         end
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop  = ascii_valid && ascii_ready;
   assign w_push = w_push_req && ((r_count != c_FULL) || w_pop);
   assign w_drop = w_push_req && !w_push;

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + c_CW'(1);
         2'b01:   w_count_next = r_count - c_CW'(1);
         default: w_count_next = r_count;
      endcase
      w_rd_next   = w_pop ? (r_rd_ptr + c_AW'(1)) : r_rd_ptr;
      w_keep      = (r_count != {{c_AW{1'b0}}, w_pop});
      w_head_next = w_keep ? r_mem[w_rd_next] : w_char;
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_char;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         ascii       <= 7'd0;
         ascii_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_rd_ptr    <= w_rd_next;
         r_count     <= w_count_next;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         ascii_valid <= (w_count_next != '0);
         ascii       <= (w_count_next != '0) ? w_head_next : 7'd0;
         r_overflow  <= r_overflow | w_drop | (scan_valid && (r_state != S_IDLE));
      end
   end

   assign caps_led = r_caps;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_kbd_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_kbd_scan_decoder                                                  |
// | Scoreboard bench: reference keyboard model, randomized scancodes.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_kbd_scan_decoder;

   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  scan_data;
   logic        scan_valid;
   logic [6:0]  rom_ad;
   logic        rom_ce;
   logic [13:0] rom_dout;
   logic [6:0]  ascii;
   logic        ascii_valid;
   logic        ascii_ready;
   logic        caps_led;
   logic        overflow;

   logic [13:0] rom_img [128];
   logic [6:0]  exp_q [$];
   int          n_vec = 0;
   int          n_fail = 0;
   logic        rand_en;
   logic        m_brk, m_ext, m_ls, m_rs, m_ctrl, m_caps, m_ovf;

   kbd_scan_decoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .reset(reset), .scan_data(scan_data), .scan_valid(scan_valid),
      .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_dout(rom_dout),
      .ascii(ascii), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
      .caps_led(caps_led), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Registered-output lookup ROM
   always @(posedge clk) if (rom_ce) rom_dout <= rom_img[rom_ad];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_en) ascii_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic monitor();
      logic [6:0] e;
      forever begin
         @(negedge clk);
         if (!reset && ascii_valid && ascii_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_char: got 0x%0h, expected none at %0t", ascii, $time);
            end else begin
               e = exp_q.pop_front();
               if (ascii !== e) begin
                  n_fail++;
                  $display("FAIL ascii: got 0x%0h, expected 0x%0h at %0t", ascii, e, $time);
               end
            end
         end
      end
   endtask

   task automatic model_reset();
      m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0; m_ctrl = 0; m_caps = 0; m_ovf = 0;
      exp_q.delete();
   endtask

   function automatic logic is_lookup(input logic [7:0] b);
      if (b >= 8'h80 || m_brk) return 1'b0;
      if (b == 8'h12 || b == 8'h59 || b == 8'h14 || b == 8'h58) return 1'b0;
      if (m_ext && b != 8'h4A && b != 8'h5A) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [6:0] model_char(input logic [6:0] code);
      logic [13:0] e;
      logic [6:0]  unsh, sh, c;
      logic        use_sh;
      e = rom_img[code];
      unsh = e[6:0];
      sh = e[13:7];
      use_sh = m_ls | m_rs;
      if (m_caps && unsh >= 7'h61 && unsh <= 7'h7A) use_sh = !use_sh;
      c = use_sh ? sh : unsh;
      if (m_ctrl && c >= 7'h40) c = c & 7'h1F;
      return c;
   endfunction

   task automatic model_apply(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (b == 8'h12) m_ls = !m_brk;
         if (b == 8'h59) m_rs = !m_brk;
         if (b == 8'h14) m_ctrl = !m_brk;
         if (b == 8'h58 && !m_brk) m_caps = !m_caps;
         m_brk = 0;
         m_ext = 0;
      end
   endtask

   task automatic expect_lookup(input logic [7:0] b);
      logic [6:0] c;
      c = model_char(b[6:0]);
      if (c != 7'd0) begin
         if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(c);
         else m_ovf = 1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic lk;
      int   g;
      lk = is_lookup(b);
      if (lk && rand_en) begin
         g = 0;
         while (exp_q.size() >= FIFO_DEPTH && g < 200) begin tick(); g++; end
         if (g >= 200) begin
            n_vec++; n_fail++;
            $display("FAIL fifo_space_wait: got %0d queued, expected < %0d", exp_q.size(), FIFO_DEPTH);
         end
      end
      if (lk) expect_lookup(b);
      model_apply(b);
      tick();
      scan_data = b;
      scan_valid = 1;
      tick();
      scan_valid = 0;
      chk("rom_ce", rom_ce, lk);
      if (lk) chk("rom_ad", rom_ad, b[6:0]);
      chk("caps_led", caps_led, m_caps);
      if (lk) begin
         tick();
         chk("rom_ce_pulse", rom_ce, 0);
      end
   endtask

   task automatic wait_drain();
      int g;
      rand_en = 0;
      ascii_ready = 1;
      g = 0;
      while (exp_q.size() != 0 && g < 200) begin tick(); g++; end
      if (exp_q.size() != 0) begin
         n_vec++; n_fail++;
         $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) tick();
      chk("drained_valid", ascii_valid, 0);
   endtask

   task automatic do_reset();
      reset = 1;
      model_reset();
      repeat (2) tick();
      reset = 0;
   endtask

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 9))
         0: return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
         1: return 8'h14;
         2: return 8'h58;
         3: return 8'hE0;
         4: return 8'hF0;
         5: return ($urandom_range(0, 1) != 0) ? 8'h4A : 8'h5A;
         6: case ($urandom_range(0, 5))
               0: return 8'hAA;
               1: return 8'hFA;
               2: return 8'hFE;
               3: return 8'hEE;
               4: return 8'hFF;
               default: return 8'h83;
            endcase
         default: return 8'($urandom_range(0, 127));
      endcase
   endfunction

   initial begin
      int k;
      reset = 1; scan_valid = 0; scan_data = 0; ascii_ready = 1; rand_en = 0;
      for (int i = 0; i < 128; i++) begin
         case ($urandom_range(0, 3))
            0: rom_img[i] = 14'd0;
            1: begin
               k = $urandom_range(0, 25);
               rom_img[i] = {7'(32'h41 + k), 7'(32'h61 + k)};
            end
            2: rom_img[i] = 14'($urandom);
            default: rom_img[i] = {7'($urandom_range(32, 126)), 7'($urandom_range(32, 126))};
         endcase
      end
      rom_img[8'h1C] = {7'h41, 7'h61};
      rom_img[8'h16] = {7'h21, 7'h31};
      rom_img[8'h5A] = {7'h0D, 7'h0D};
      rom_img[8'h05] = 14'd0;
      model_reset();
      fork monitor(); join_none
      repeat (3) tick();
      reset = 0;
      tick();
      chk("rst_rom_ad", rom_ad, 0);
      chk("rst_rom_ce", rom_ce, 0);
      chk("rst_ascii", ascii, 0);
      chk("rst_ascii_valid", ascii_valid, 0);
      chk("rst_caps_led", caps_led, 0);
      chk("rst_overflow", overflow, 0);

      // Basic lookup latency
      send(8'h1C);
      tick();
      chk("lat_valid", ascii_valid, 1);
      chk("lat_ascii", ascii, 7'h61);
      tick();
      chk("lat_empty", ascii_valid, 0);
      wait_drain();

      // Shift make/break
      send(8'h12); send(8'h16); send(8'hF0); send(8'h12); send(8'h16);
      wait_drain();

      // CapsLock and Ctrl
      send(8'h58); send(8'h1C);
      chk("caps_on", caps_led, 1);
      wait_drain();
      send(8'h12); send(8'h1C);
      wait_drain();
      send(8'hF0); send(8'h12); send(8'h14); send(8'h1C);
      wait_drain();
      send(8'hF0); send(8'h14); send(8'h58);

      // Ignored and extended codes
      send(8'h05); send(8'hF0); send(8'h1C); send(8'hE0); send(8'h75);
      send(8'hE0); send(8'h5A); send(8'hAA); send(8'h1C);
      wait_drain();

      // Randomized traffic with random consumer back-pressure
      rand_en = 1;
      repeat (300) send(rand_byte());
      wait_drain();
      chk("rand_no_overflow", overflow, 0);

      // FIFO overflow
      do_reset();
      ascii_ready = 0;
      repeat (5) send(8'h1C);
      tick();
      chk("ovf_flag", overflow, 1);
      chk("ovf_model", overflow, m_ovf);
      chk("ovf_valid_held", ascii_valid, 1);
      wait_drain();

      // Reset in the middle of a lookup
      send(8'h58);
      tick();
      scan_data = 8'h1C;
      scan_valid = 1;
      tick();
      scan_valid = 0;
      reset = 1;
      tick();
      reset = 0;
      model_reset();
      chk("mid_rom_ad", rom_ad, 0);
      chk("mid_rom_ce", rom_ce, 0);
      chk("mid_ascii", ascii, 0);
      chk("mid_ascii_valid", ascii_valid, 0);
      chk("mid_caps_led", caps_led, 0);
      chk("mid_overflow", overflow, 0);
      repeat (4) tick();
      chk("mid_no_push", ascii_valid, 0);
      send(8'h1C);
      wait_drain();

      // Byte arriving during FETCH is dropped
      tick();
      expect_lookup(8'h1C);
      model_apply(8'h1C);
      scan_data = 8'h1C;
      scan_valid = 1;
      tick();
      scan_data = 8'h58;
      tick();
      scan_valid = 0;
      m_ovf = 1;
      chk("drop_overflow", overflow, m_ovf);
      chk("drop_caps", caps_led, m_caps);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
